clock_display_scan: RTL and testbench

- Downstream consumer of the hours/minutes/seconds time counter.
- Converts the binary time fields to decimal digits and time-multiplexes them onto a 6-digit common-anode 7-segment display (HH MM SS), with colon dots.
- Captures a coherent snapshot of the time once per scan frame, so a carry from seconds into minutes or hours never shows a torn value.

---
 rtl/clock_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 32 +++
 rtl/clock_display_scan.sv | 137 +++++++++++++
 tb/tb_clock_display_scan.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared clock constants, segment codes and BCD helper
package clock_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [6:0] seg_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  function automatic logic [7:0] bin2bcd_2d(input logic [5:0] v);
    logic [5:0] tens;
    logic [5:0] units;
    tens  = v / 6'd10;
    units = v - (tens * 6'd10);
    return {tens[3:0], units[3:0]};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - one decimal digit to active-low 7-segment pattern
module seg7_decode
  import clock_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       dash_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else if (!dash_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - HH MM SS time-multiplexed 6-digit 7-segment scanner
module clock_display_scan
  import clock_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LEAD  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [5:0] anode,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hr_q, hr_d;
  logic             tick, tick_q;
  logic [5:0]       anode_q, anode_d;
  seg_t             seg_q, seg_d;
  logic             dp_q, dp_d;

  assign tick = (div_cnt_q == DIV_LAST);

  // The snapshot is only taken as the scan wraps to digit 0, so a whole frame is coherent
  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    if (tick) begin
      digit_idx_d = (digit_idx_q == LAST_DIGIT) ? 3'd0 : digit_idx_q + 3'd1;
      if (digit_idx_d == 3'd0) begin
        sec_d = seconds;
        min_d = minutes;
        hr_d  = hours;
      end
    end
  end

  logic [7:0] bcd_sec, bcd_min, bcd_hr;
  logic       sec_ok, min_ok, hr_ok;
  logic [3:0] mux_digit;
  logic       mux_dash, mux_blank;

  assign bcd_sec = bin2bcd_2d(sec_q);
  assign bcd_min = bin2bcd_2d(min_q);
  assign bcd_hr  = bin2bcd_2d({1'b0, hr_q});
  assign sec_ok  = (sec_q <= SEC_MAX);
  assign min_ok  = (min_q <= MIN_MAX);
  assign hr_ok   = (hr_q <= HR_MAX);

  always_comb begin
    mux_digit = 4'd0;
    mux_dash  = 1'b0;
    mux_blank = 1'b0;
    case (digit_idx_q)
      3'd0: begin
        mux_digit = bcd_hr[7:4];
        mux_dash  = !hr_ok;
        mux_blank = BLANK_LEAD && hr_ok && (hr_q < 5'd10);
      end
      3'd1: begin
        mux_digit = bcd_hr[3:0];
        mux_dash  = !hr_ok;
      end
      3'd2: begin
        mux_digit = bcd_min[7:4];
        mux_dash  = !min_ok;
      end
      3'd3: begin
        mux_digit = bcd_min[3:0];
        mux_dash  = !min_ok;
      end
      3'd4: begin
        mux_digit = bcd_sec[7:4];
        mux_dash  = !sec_ok;
      end
      default: begin
        mux_digit = bcd_sec[3:0];
        mux_dash  = !sec_ok;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit_i (mux_digit),
    .dash_i  (mux_dash),
    .blank_i (mux_blank),
    .seg_o   (seg_d)
  );

  // Colon dots follow digits 1 and 3 and blink with the seconds LSB
  assign dp_d    = ~(((digit_idx_q == 3'd1) || (digit_idx_q == 3'd3)) && !sec_q[0]);
  assign anode_d = ~(6'b1 << digit_idx_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      digit_idx_q <= LAST_DIGIT;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      tick_q      <= 1'b0;
      anode_q     <= 6'h3F;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      tick_q      <= tick;
      if (tick_q) begin
        anode_q <= anode_d;
        seg_q   <= seg_d;
        dp_q    <= dp_d;
      end
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - scoreboard bench for clock_display_scan
module tb_clock_display_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 6 * DIV;
  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [5:0] anode, anode0;
  logic [6:0] seg, seg0;
  logic       dp, dp0;

  always #5 clk = ~clk;

  clock_display_scan #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b1)) u_dut (
    .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
    .anode(anode), .seg(seg), .dp(dp)
  );

  clock_display_scan #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
    .anode(anode0), .seg(seg0), .dp(dp0)
  );

  typedef struct {
    int         due;
    logic [5:0] an;
    logic [6:0] sg;
    logic [6:0] sg0;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what a viewer should see for each digit of a frame showing hh:mm:ss
  task automatic push_frame(input int hh, input int mm, input int ss, input int start);
    for (int d = 0; d < 6; d++) begin
      exp_t e;
      int   v, mx;
      v  = (d < 2) ? hh : (d < 4) ? mm : ss;
      mx = (d < 2) ? 23 : 59;
      e.due = start + 1 + d * DIV;
      e.an  = 6'h3F ^ (6'b1 << d);
      e.sg  = (v > mx) ? 7'h3F : SEG_TAB[(d % 2 == 0) ? v / 10 : v % 10];
      e.sg0 = e.sg;
      if (d == 0 && hh <= 23 && hh < 10) e.sg = 7'h7F;
      e.dp  = ((d == 1 || d == 3) && (ss % 2 == 0)) ? 1'b0 : 1'b1;
      sb.push_back(e);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0;
      sb.delete();
    end else begin
      cyc++;
      if (cyc >= DIV && (cyc - DIV) % FRAME == 0) push_frame(int'(hours), int'(minutes), int'(seconds), cyc);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      cur = '{due: 0, an: 6'h3F, sg: 7'h7F, sg0: 7'h7F, dp: 1'b1};
      check("rst_anode", anode, 6'h3F);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_anode_bl0", anode0, 6'h3F);
    end else begin
      if ({anode, seg, dp} !== {cur.an, cur.sg, cur.dp}) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_update: got anode=%0h seg=%0h dp=%0b with nothing pending (cycle %0d)",
                   anode, seg, dp, cyc);
        end else begin
          cur = sb.pop_front();
          check("update_cycle", cyc, cur.due);
          check("anode", anode, cur.an);
          check("seg", seg, cur.sg);
          check("dp", dp, cur.dp);
        end
      end
      check("anode_bl0", anode0, cur.an);
      check("seg_bl0", seg0, cur.sg0);
      check("dp_bl0", dp0, cur.dp);
    end
  end

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) begin
      total++;
      bad++;
      $display("FAIL wait_cycle: got %0d expected %0d", cyc, target);
    end
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    hours   = 5'(hh);
    minutes = 6'(mm);
    seconds = 6'(ss);
  endtask

  initial begin
    int missed;
    int s;
    set_time(23, 59, 58);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    wait_cyc(27);  set_time(0, 59, 59);
    wait_cyc(42);  set_time(1, 0, 0);      // mid-frame change, must not tear
    wait_cyc(70);  set_time(5, 12, 7);
    wait_cyc(94);  set_time(5, 12, 8);
    wait_cyc(118); set_time(14, 33, 60);
    wait_cyc(142); set_time(24, 61, 33);
    wait_cyc(166); set_time(31, 63, 63);
    wait_cyc(190);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      set_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end
    set_time(9, 45, 12);

    s = DIV + ((cyc - DIV) / FRAME + 1) * FRAME;
    wait_cyc(s + 10);
    #2 reset = 1'b0;
    #1;
    check("async_rst_anode", anode, 6'h3F);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dp", dp, 1'b1);
    set_time(10, 20, 30);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_cyc(DIV + 2 * FRAME + 2);

    missed = 0;
    foreach (sb[i]) if (sb[i].due <= cyc) missed++;
    check("missed_updates", missed, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
